// File: rtl/pcie_msg_pkg.sv
// pcie_msg_pkg: shared fragment-header layout, FragType codes and AXI constants
// for the PCIe message fragmenter and receiver.
package pcie_msg_pkg;

   localparam logic [1:0] FT_M  = 2'b00;
   localparam logic [1:0] FT_L  = 2'b01;
   localparam logic [1:0] FT_S  = 2'b10;
   localparam logic [1:0] FT_SG = 2'b11;

   localparam int HDR_FT_LSB  = 126;
   localparam int HDR_SN_LSB  = 124;
   localparam int HDR_TAG_LSB = 120;

   localparam logic [2:0] AXI_SIZE_32B   = 3'b101;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   localparam logic [3:0] TAG_ILLEGAL = 4'hF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_AW,
      ST_W_HDR,
      ST_W_PL,
      ST_B,
      ST_DONE,
      ST_DRAIN
   } frag_state_t;

   function automatic logic [127:0] make_hdr(input logic [1:0] ft, input logic [1:0] sn,
                                             input logic [3:0] tag, input logic [119:0] tlp);
      logic [127:0] h;
      h = '0;
      h[HDR_FT_LSB +: 2]  = ft;
      h[HDR_SN_LSB +: 2]  = sn;
      h[HDR_TAG_LSB +: 4] = tag;
      h[119:0]            = tlp;
      return h;
   endfunction

endpackage

// File: rtl/pcie_frag_hdr_gen.sv
// pcie_frag_hdr_gen: builds the 128-bit fragment header and the burst awlen
// for fragment k of nfrag, given the message beats still to send.
module pcie_frag_hdr_gen
   import pcie_msg_pkg::*;
#(
   parameter int MAX_PL_BEATS = 15
) (
   input  logic [7:0]   k,
   input  logic [7:0]   nfrag,
   input  logic [7:0]   rem,
   input  logic [3:0]   tag,
   input  logic [119:0] tlp,
   output logic [127:0] hdr,
   output logic [11:0]  awlen
);

   localparam logic [7:0] MAX_B = 8'(MAX_PL_BEATS);

   logic [1:0] ft;

   always_comb begin
      ft    = nfrag == 8'd1 ? FT_SG :
              k == 8'd0 ? FT_S :
              k == nfrag - 8'd1 ? FT_L : FT_M;
      hdr   = make_hdr(ft, k[1:0], tag, tlp);
      awlen = {4'd0, rem > MAX_B ? MAX_B : rem};
   end

endmodule

// File: rtl/pcie_msg_fragmenter.sv
// pcie_msg_fragmenter: splits one message into header-prefixed AXI write bursts,
// one burst outstanding at a time; illegal tags drain the payload without AXI traffic.
module pcie_msg_fragmenter
   import pcie_msg_pkg::*;
#(
   parameter int MAX_PL_BEATS = 15
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [119:0] cmd_tlp,
   input  logic [3:0]   cmd_tag,
   input  logic [7:0]   cmd_len,
   input  logic [63:0]  cmd_addr,
   input  logic         pl_valid,
   input  logic [255:0] pl_data,
   output logic         pl_ready,
   output logic         axi_awvalid,
   input  logic         axi_awready,
   output logic [63:0]  axi_awaddr,
   output logic [11:0]  axi_awlen,
   output logic [2:0]   axi_awsize,
   output logic [1:0]   axi_awburst,
   output logic         axi_wvalid,
   input  logic         axi_wready,
   output logic [255:0] axi_wdata,
   output logic [31:0]  axi_wstrb,
   output logic         axi_wlast,
   input  logic         axi_bvalid,
   input  logic [1:0]   axi_bresp,
   output logic         axi_bready,
   output logic         msg_done,
   output logic         msg_err
);

   frag_state_t state, state_n;
   logic         run;
   logic [119:0] tlp;
   logic [3:0]   tag;
   logic [63:0]  addr;
   logic [7:0]   rem, left, k, nfrag;
   logic         err;
   logic [127:0] hdr;
   logic [11:0]  frag_awlen;
   logic [8:0]   len_sum;
   logic [7:0]   nfrag_q, nfrag_cmd;
   logic         accept, pl_fire;

   assign len_sum   = {1'b0, cmd_len} + 9'(MAX_PL_BEATS - 1);
   assign nfrag_q   = 8'(len_sum / 9'(MAX_PL_BEATS));
   assign nfrag_cmd = nfrag_q == 8'd0 ? 8'd1 : nfrag_q;
   assign accept    = cmd_ready && cmd_valid;
   assign pl_fire   = pl_valid && pl_ready;

   pcie_frag_hdr_gen #(.MAX_PL_BEATS(MAX_PL_BEATS)) u_hdr (
      .k     (k),
      .nfrag (nfrag),
      .rem   (rem),
      .tag   (tag),
      .tlp   (tlp),
      .hdr   (hdr),
      .awlen (frag_awlen)
   );

   assign axi_awaddr  = addr;
   assign axi_awlen   = frag_awlen;
   assign axi_awsize  = AXI_SIZE_32B;
   assign axi_awburst = AXI_BURST_INCR;
   assign axi_wstrb   = {32{axi_wvalid}};
   assign msg_err     = msg_done && err;

   always_comb begin
      state_n     = state;
      cmd_ready   = 1'b0;
      pl_ready    = 1'b0;
      axi_awvalid = 1'b0;
      axi_wvalid  = 1'b0;
      axi_wdata   = '0;
      axi_wlast   = 1'b0;
      axi_bready  = 1'b0;
      msg_done    = 1'b0;
      case (state)
         ST_IDLE: begin
            cmd_ready = run;
            if (run && cmd_valid) state_n = cmd_tag == TAG_ILLEGAL ? ST_DRAIN : ST_AW;
         end
         ST_AW: begin
            axi_awvalid = 1'b1;
            if (axi_awready) state_n = ST_W_HDR;
         end
         ST_W_HDR: begin
            axi_wvalid = 1'b1;
            axi_wdata  = {128'd0, hdr};
            axi_wlast  = frag_awlen == 12'd0;
            if (axi_wready) state_n = frag_awlen == 12'd0 ? ST_B : ST_W_PL;
         end
         // payload is a straight combinational pass-through
         ST_W_PL: begin
            axi_wvalid = pl_valid;
            pl_ready   = axi_wready;
            axi_wdata  = pl_data;
            axi_wlast  = pl_valid && left == 8'd1;
            if (pl_fire && left == 8'd1) state_n = ST_B;
         end
         ST_B: begin
            axi_bready = 1'b1;
            if (axi_bvalid) state_n = k == nfrag - 8'd1 ? ST_DONE : ST_AW;
         end
         ST_DONE: begin
            msg_done = 1'b1;
            state_n  = ST_IDLE;
         end
         ST_DRAIN: begin
            pl_ready = rem != 8'd0;
            if (rem == 8'd0) state_n = ST_DONE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         run   <= 1'b0;
         tlp   <= '0;
         tag   <= '0;
         addr  <= '0;
         rem   <= '0;
         left  <= '0;
         k     <= '0;
         nfrag <= '0;
         err   <= 1'b0;
      end else begin
         state <= state_n;
         run   <= 1'b1;
         if (accept) begin
            tlp   <= cmd_tlp;
            tag   <= cmd_tag;
            addr  <= cmd_addr;
            rem   <= cmd_len;
            k     <= 8'd0;
            nfrag <= nfrag_cmd;
            err   <= cmd_tag == TAG_ILLEGAL;
         end
         if (state == ST_W_HDR && axi_wready) left <= frag_awlen[7:0];
         if (pl_fire) begin
            rem  <= rem - 8'd1;
            left <= left - 8'd1;
         end
         if (state == ST_B && axi_bvalid) begin
            err <= err | (axi_bresp != AXI_RESP_OKAY);
            k   <= k + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_pcie_msg_fragmenter.sv
// tb_pcie_msg_fragmenter: directed scenarios against an AXI slave model that
// reassembles bursts and tracks handshake protocol violations.
module tb_pcie_msg_fragmenter;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         cmd_valid = 1'b0;
   logic         cmd_ready;
   logic [119:0] cmd_tlp = '0;
   logic [3:0]   cmd_tag = '0;
   logic [7:0]   cmd_len = '0;
   logic [63:0]  cmd_addr = '0;
   logic         pl_valid = 1'b0;
   logic [255:0] pl_data = '0;
   logic         pl_ready;
   logic         axi_awvalid;
   logic         axi_awready = 1'b0;
   logic [63:0]  axi_awaddr;
   logic [11:0]  axi_awlen;
   logic [2:0]   axi_awsize;
   logic [1:0]   axi_awburst;
   logic         axi_wvalid;
   logic         axi_wready = 1'b0;
   logic [255:0] axi_wdata;
   logic [31:0]  axi_wstrb;
   logic         axi_wlast;
   logic         axi_bvalid = 1'b0;
   logic [1:0]   axi_bresp = 2'b00;
   logic         axi_bready;
   logic         msg_done;
   logic         msg_err;

   localparam logic [119:0] TLP_A = 120'h0123456789ABCDEF0123456789ABCD;
   localparam logic [119:0] TLP_B = 120'hFEDCBA9876543210FEDCBA98765432;

   int checks = 0;
   int failures = 0;

   logic [11:0]  awlen_q[$];
   logic [127:0] hdr_q[$];
   logic [255:0] pl_q[$];
   int   viol = 0, beat_idx = 0, cur_len = 0, bcnt = 0, err_burst = -1;
   int   done_cnt = 0, cyc = 0, last_b_cyc = 0, done_cyc = 0;
   bit   bp = 0, b_pend = 0, b_hs = 0, aw_hold = 0, w_hold = 0;
   bit   prev_done = 0, done_err = 0, ready_after_done = 0;
   logic [63:0]  exp_addr = '0, hold_awaddr;
   logic [11:0]  hold_awlen;
   logic [255:0] hold_wdata;
   logic         hold_wlast;

   pcie_msg_fragmenter #(.MAX_PL_BEATS(15)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_tlp(cmd_tlp),
      .cmd_tag(cmd_tag), .cmd_len(cmd_len), .cmd_addr(cmd_addr),
      .pl_valid(pl_valid), .pl_data(pl_data), .pl_ready(pl_ready),
      .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
      .axi_awlen(axi_awlen), .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
      .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
      .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
      .axi_bvalid(axi_bvalid), .axi_bresp(axi_bresp), .axi_bready(axi_bready),
      .msg_done(msg_done), .msg_err(msg_err)
   );

   always #5 clk = ~clk;

   // AXI slave: drives ready/B at negedge, samples handshakes 1ns before posedge
   always @(negedge clk) begin
      if (rst) begin
         axi_awready = 1'b0;
         axi_wready  = 1'b0;
         axi_bvalid  = 1'b0;
         axi_bresp   = 2'b00;
         b_pend = 0; b_hs = 0; aw_hold = 0; w_hold = 0; beat_idx = 0; prev_done = 0;
      end else begin
         axi_awready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         axi_wready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         if (b_hs) begin
            axi_bvalid = 1'b0;
            b_hs = 0;
         end
         if (!axi_bvalid && b_pend && (!bp || $urandom_range(0, 2) == 0)) begin
            axi_bvalid = 1'b1;
            axi_bresp  = bcnt == err_burst ? 2'b10 : 2'b00;
         end
         #4;
         if (!rst) begin
            cyc++;
            if (aw_hold && (!axi_awvalid || axi_awaddr !== hold_awaddr || axi_awlen !== hold_awlen)) viol++;
            if (w_hold && (!axi_wvalid || axi_wdata !== hold_wdata || axi_wlast !== hold_wlast)) viol++;
            aw_hold = axi_awvalid && !axi_awready;
            hold_awaddr = axi_awaddr;
            hold_awlen = axi_awlen;
            w_hold = axi_wvalid && !axi_wready;
            hold_wdata = axi_wdata;
            hold_wlast = axi_wlast;
            if (axi_awvalid && axi_awready) begin
               awlen_q.push_back(axi_awlen);
               cur_len = int'(axi_awlen);
               beat_idx = 0;
               if (axi_awaddr !== exp_addr || axi_awsize !== 3'b101 || axi_awburst !== 2'b01) viol++;
            end
            if (axi_wvalid && axi_wready) begin
               if (axi_wstrb !== 32'hFFFF_FFFF) viol++;
               if (axi_wlast !== (beat_idx == cur_len)) viol++;
               if (beat_idx == 0) begin
                  hdr_q.push_back(axi_wdata[127:0]);
                  if (axi_wdata[255:128] !== '0) viol++;
               end else pl_q.push_back(axi_wdata);
               beat_idx++;
               if (axi_wlast) b_pend = 1;
            end
            if (axi_bvalid && axi_bready) begin
               b_hs = 1; b_pend = 0; bcnt++; last_b_cyc = cyc;
            end
            if (prev_done) ready_after_done = cmd_ready;
            prev_done = msg_done;
            if (msg_done) begin
               done_cnt++; done_err = msg_err; done_cyc = cyc;
            end
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic clear_model();
      awlen_q.delete(); hdr_q.delete(); pl_q.delete();
      viol = 0; bcnt = 0; err_burst = -1;
   endtask

   task automatic issue_cmd(input logic [119:0] tlp, input logic [3:0] tag,
                            input logic [7:0] len, input logic [63:0] addr, output bit ok);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_tlp = tlp; cmd_tag = tag; cmd_len = len; cmd_addr = addr;
      exp_addr = addr;
      ok = 0;
      for (int n = 0; n < 50 && !ok; n++) begin
         #4;
         if (cmd_ready) ok = 1;
         @(negedge clk);
      end
      cmd_valid = 1'b0;
   endtask

   task automatic send_payload(input int n, input int msg, input bit gaps, output int got);
      int i = 0;
      bit acc = 1;
      for (int b = 0; b < 20000 && i < n; b++) begin
         @(negedge clk);
         if (acc || !pl_valid) pl_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         acc = 0;
         pl_data = {192'd0, 32'(msg), 32'(i)};
         #4;
         if (pl_valid && pl_ready) begin
            i++; acc = 1;
         end
      end
      @(negedge clk);
      pl_valid = 1'b0;
      got = i;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      int start = done_cnt;
      ok = 0;
      for (int n = 0; n < budget && !ok; n++) begin
         @(posedge clk);
         #1;
         if (done_cnt != start) ok = 1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #4;
      checks++;
      if ({cmd_ready, pl_ready, axi_awvalid, axi_wvalid, axi_wlast, axi_bready, msg_done, msg_err} !== 8'h00) begin
         failures++;
         $display("FAIL reset_ctrl got=%b want=00000000",
                  {cmd_ready, pl_ready, axi_awvalid, axi_wvalid, axi_wlast, axi_bready, msg_done, msg_err});
      end
      checks++;
      if (axi_awaddr !== '0 || axi_awlen !== '0 || axi_wdata !== '0 || axi_wstrb !== '0) begin
         failures++;
         $display("FAIL reset_data awaddr=%h awlen=%h wstrb=%h want all zero", axi_awaddr, axi_awlen, axi_wstrb);
      end
      @(negedge clk);
      rst = 1'b0;
      #4;
      checks++;
      if (cmd_ready !== 1'b0) begin
         failures++;
         $display("FAIL ready_before_edge got=%b want=0", cmd_ready);
      end
      @(negedge clk);
      #4;
      checks++;
      if (cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL ready_after_reset got=%b want=1", cmd_ready);
      end
   endtask

   task automatic test_single();
      bit ok, dn;
      int got, bad = 0;
      clear_model();
      issue_cmd(TLP_A, 4'd3, 8'd4, 64'h0000_1000_0000_0040, ok);
      #4;
      checks++;
      if (!ok || axi_awvalid !== 1'b1 || axi_awlen !== 12'd4) begin
         failures++;
         $display("FAIL single_aw accepted=%0d awvalid=%b awlen=%0d want 1/1/4", ok, axi_awvalid, axi_awlen);
      end
      @(negedge clk);
      #4;
      checks++;
      if (axi_wvalid !== 1'b1 || axi_wdata[127:0] !== {8'hC3, TLP_A} || axi_wlast !== 1'b0) begin
         failures++;
         $display("FAIL single_hdr wvalid=%b hdr=%h wlast=%b want 1/%h/0",
                  axi_wvalid, axi_wdata[127:0], axi_wlast, {8'hC3, TLP_A});
      end
      fork
         send_payload(4, 1, 0, got);
         wait_done(200, dn);
      join
      checks++;
      if (!dn || done_err !== 1'b0) begin
         failures++;
         $display("FAIL single_done done=%0d err=%b want 1/0", dn, done_err);
      end
      for (int j = 0; j < 4; j++) if (pl_q[j] !== {192'd0, 32'd1, 32'(j)}) bad++;
      checks++;
      if (pl_q.size() != 4 || bad != 0 || awlen_q.size() != 1) begin
         failures++;
         $display("FAIL single_beats pl=%0d bad=%0d bursts=%0d want 4/0/1", pl_q.size(), bad, awlen_q.size());
      end
      checks++;
      if (viol != 0) begin
         failures++;
         $display("FAIL single_protocol violations=%0d want 0", viol);
      end
      checks++;
      if (done_cyc - last_b_cyc != 1) begin
         failures++;
         $display("FAIL single_done_latency got=%0d want 1", done_cyc - last_b_cyc);
      end
      @(negedge clk);
      #4;
      checks++;
      if (ready_after_done !== 1'b1) begin
         failures++;
         $display("FAIL single_ready_after_done got=%b want 1", ready_after_done);
      end
   endtask

   task automatic test_multi();
      logic [7:0] exp_top [3] = '{8'h85, 8'h15, 8'h65};
      int exp_len [3] = '{15, 15, 10};
      bit ok, dn;
      int got, bad = 0;
      clear_model();
      issue_cmd(TLP_B, 4'd5, 8'd40, 64'hA000_0000_0000_1000, ok);
      fork
         send_payload(40, 2, 0, got);
         wait_done(500, dn);
      join
      checks++;
      if (!ok || !dn || done_err !== 1'b0 || awlen_q.size() != 3) begin
         failures++;
         $display("FAIL multi_done ok=%0d done=%0d err=%b bursts=%0d want 1/1/0/3", ok, dn, done_err, awlen_q.size());
      end
      for (int f = 0; f < 3; f++) begin
         checks++;
         if (awlen_q[f] !== 12'(exp_len[f]) || hdr_q[f] !== {exp_top[f], TLP_B}) begin
            failures++;
            $display("FAIL multi_frag%0d awlen=%0d hdr=%h want %0d/%h", f, awlen_q[f], hdr_q[f], exp_len[f], {exp_top[f], TLP_B});
         end
      end
      for (int j = 0; j < 40; j++) if (pl_q[j] !== {192'd0, 32'd2, 32'(j)}) bad++;
      checks++;
      if (pl_q.size() != 40 || bad != 0 || viol != 0) begin
         failures++;
         $display("FAIL multi_reassembly beats=%0d bad=%0d viol=%0d want 40/0/0", pl_q.size(), bad, viol);
      end
   endtask

   task automatic test_long_backpressure();
      bit ok, dn;
      int got, bad = 0;
      logic [7:0] top;
      clear_model();
      bp = 1;
      issue_cmd(TLP_A, 4'd2, 8'd255, 64'h0000_0000_DEAD_B000, ok);
      fork
         send_payload(255, 3, 1, got);
         wait_done(20000, dn);
      join
      bp = 0;
      checks++;
      if (!ok || !dn || done_err !== 1'b0 || awlen_q.size() != 17) begin
         failures++;
         $display("FAIL long_done ok=%0d done=%0d err=%b bursts=%0d want 1/1/0/17", ok, dn, done_err, awlen_q.size());
      end
      for (int f = 0; f < 17; f++) begin
         top = f == 0 ? 8'h82 : f == 16 ? 8'h42 : {2'b00, 2'(f % 4), 4'h2};
         checks++;
         if (awlen_q[f] !== 12'd15 || hdr_q[f] !== {top, TLP_A}) begin
            failures++;
            $display("FAIL long_frag%0d awlen=%0d hdr_top=%h want 15/%h", f, awlen_q[f], hdr_q[f][127:120], top);
         end
      end
      for (int j = 0; j < 255; j++) if (pl_q[j] !== {192'd0, 32'd3, 32'(j)}) bad++;
      checks++;
      if (pl_q.size() != 255 || bad != 0) begin
         failures++;
         $display("FAIL long_reassembly beats=%0d bad=%0d want 255/0", pl_q.size(), bad);
      end
      checks++;
      if (viol != 0) begin
         failures++;
         $display("FAIL long_protocol violations=%0d want 0", viol);
      end
   endtask

   task automatic test_illegal_tag();
      bit ok, dn;
      int got;
      clear_model();
      issue_cmd(TLP_B, 4'hF, 8'd3, 64'h1234, ok);
      fork
         send_payload(3, 4, 0, got);
         wait_done(200, dn);
      join
      checks++;
      if (!ok || !dn || done_err !== 1'b1) begin
         failures++;
         $display("FAIL illegal_done ok=%0d done=%0d err=%b want 1/1/1", ok, dn, done_err);
      end
      checks++;
      if (got != 3) begin
         failures++;
         $display("FAIL illegal_drain consumed=%0d want 3", got);
      end
      checks++;
      if (awlen_q.size() != 0 || hdr_q.size() != 0 || pl_q.size() != 0) begin
         failures++;
         $display("FAIL illegal_no_axi aw=%0d w=%0d want 0/0", awlen_q.size(), hdr_q.size() + pl_q.size());
      end
   endtask

   task automatic test_bresp_err_then_reset();
      bit ok, dn, seen = 0;
      int got;
      clear_model();
      err_burst = 1;
      issue_cmd(TLP_A, 4'd6, 8'd40, 64'h55AA, ok);
      fork
         send_payload(40, 5, 0, got);
         wait_done(500, dn);
      join
      checks++;
      if (!dn || done_err !== 1'b1) begin
         failures++;
         $display("FAIL bresp_err done=%0d err=%b want 1/1", dn, done_err);
      end
      checks++;
      if (awlen_q.size() != 3 || pl_q.size() != 40 || bcnt != 3) begin
         failures++;
         $display("FAIL bresp_continue bursts=%0d beats=%0d b=%0d want 3/40/3", awlen_q.size(), pl_q.size(), bcnt);
      end
      clear_model();
      issue_cmd(TLP_B, 4'd1, 8'd20, 64'h99, ok);
      pl_valid = 1'b1;
      pl_data = {192'd0, 32'd6, 32'd0};
      for (int n = 0; n < 50 && !seen; n++) begin
         @(negedge clk);
         #4;
         if (pl_ready) seen = 1;
      end
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (!seen || {cmd_ready, pl_ready, axi_awvalid, axi_wvalid, axi_wlast, axi_bready, msg_done, msg_err} !== 8'h00
          || axi_awaddr !== '0 || axi_awlen !== '0 || axi_wdata !== '0 || axi_wstrb !== '0) begin
         failures++;
         $display("FAIL midmsg_reset in_wpl=%0d ctrl=%b awaddr=%h awlen=%h want all zero", seen,
                  {cmd_ready, pl_ready, axi_awvalid, axi_wvalid, axi_wlast, axi_bready, msg_done, msg_err},
                  axi_awaddr, axi_awlen);
      end
      pl_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      #4;
      checks++;
      if (cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL midmsg_ready got=%b want 1", cmd_ready);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_multi();
      test_long_backpressure();
      test_illegal_tag();
      test_bresp_err_then_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
